// File: rtl/heap_root_controller.sv
// Root-level controller of the pipelined heap: replace (pop minimum, push key) on the
// root record, hands the popped key downstream, then kicks off the level-1 sift-down.
`timescale 1ns/1ps
module heap_root_controller #(
  parameter int WIDTH = 15,
  parameter int SPACING = 4,
  parameter logic [WIDTH:0] SENTINEL = {(WIDTH+1){1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_empty,
  input  logic [WIDTH:0]   q_root,
  output logic [WIDTH:0]   data_root,
  output logic             wren_root,
  output logic             initialize,
  output logic             update_out,
  output logic             address_updated_out
);

  localparam int CNT_W = $clog2(SPACING + 1);

  typedef enum logic [2:0] {IDLE, INIT, READY, READ, WRITE, NOTIFY, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   gap_cnt;
  logic               notify_hold;
  logic [WIDTH:0]     key_p0;
  logic               accept;

  // A new request is only taken once the previous popped key has been delivered.
  assign in_ready            = (state == READY) && !out_valid;
  assign accept              = in_ready && in_valid;
  assign address_updated_out = 1'b0;

  // Stage p0: pushed key held until the root write
  always_ff @(posedge clk) begin
    if (accept) key_p0 <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      notify_hold <= 1'b0;
      out_valid   <= 1'b0;
      out_empty   <= 1'b0;
      out_data    <= '0;
      data_root   <= '0;
      wren_root   <= 1'b0;
      initialize  <= 1'b0;
      update_out  <= 1'b0;
    end else begin
      wren_root  <= 1'b0;
      initialize <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= INIT;
            data_root  <= SENTINEL;
            wren_root  <= 1'b1;
            initialize <= 1'b1;
          end
        end
        INIT: begin
          state   <= GAP;
          gap_cnt <= CNT_W'(SPACING);
        end
        READY: begin
          if (accept) state <= READ;
        end
        READ: begin
          state     <= WRITE;
          data_root <= key_p0;
          wren_root <= 1'b1;
        end
        // q_root still shows the pre-write root here, i.e. the key being popped.
        WRITE: begin
          state       <= NOTIFY;
          out_data    <= q_root;
          out_empty   <= (q_root == SENTINEL);
          out_valid   <= 1'b1;
          update_out  <= 1'b1;
          notify_hold <= 1'b0;
        end
        NOTIFY: begin
          if (!notify_hold) begin
            notify_hold <= 1'b1;
          end else begin
            update_out <= 1'b0;
            gap_cnt    <= CNT_W'(SPACING);
            state      <= GAP;
          end
        end
        // Guard window so the level-1 swap lands through port B before the next root read.
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= CNT_W'(1)) state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_root_controller.sv
// Bench for heap_root_controller: timeline model of the replace protocol plus directed vectors.
`timescale 1ns/1ps
module tb_heap_root_controller;

  localparam int WIDTH = 15;
  localparam int SPACING = 4;
  localparam logic [WIDTH:0] SENT = 16'hFFFF;

  logic clk, rst, start, in_valid, in_ready, out_valid, out_ready, out_empty;
  logic wren_root, initialize, update_out, address_updated_out;
  logic [WIDTH:0] in_data, out_data, q_root, data_root;

  int checks = 0;
  int errors = 0;

  heap_root_controller #(.WIDTH(WIDTH), .SPACING(SPACING)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_empty(out_empty),
    .q_root(q_root), .data_root(data_root), .wren_root(wren_root),
    .initialize(initialize), .update_out(update_out),
    .address_updated_out(address_updated_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Root record memory, port A: synchronous read of address 0, read-before-write.
  logic [WIDTH:0] mem = '0;
  initial q_root = '0;
  always @(posedge clk) begin
    q_root <= mem;
    if (wren_root) mem <= data_root;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: cycle n begins at edge n; an accept at edge E gives the root write
  // in cycle E+1, the update pulse in cycles E+2..E+3 and the next ready cycle E+4+SPACING.
  int cyc = 0, t_init = -100, t_acc = -100, ready_at = 0;
  logic m_run = 0, m_ov = 0, m_oe = 0, acc;
  logic e_ir = 0, e_wren = 0, e_init = 0, e_upd = 0;
  logic [WIDTH:0] m_od = '0, m_root = '0, pop = '0, acc_key = '0, e_wdata = '0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_run = 0; t_init = -100; t_acc = -100; ready_at = 0;
      m_ov = 0; m_oe = 0; m_od = '0;
      e_ir = 0; e_wren = 0; e_init = 0; e_upd = 0;
    end else begin
      cyc = cyc + 1;
      acc = e_ir && in_valid;
      if (m_ov && out_ready) m_ov = 0;
      if (!m_run && start) begin
        m_run = 1; t_init = cyc; ready_at = cyc + 1 + SPACING; m_root = SENT;
      end
      if (acc) begin
        t_acc = cyc; acc_key = in_data; pop = m_root; m_root = in_data;
        ready_at = cyc + 4 + SPACING;
      end
      if (cyc == t_acc + 2) begin
        m_ov = 1; m_od = pop; m_oe = (pop == SENT);
      end
      e_init = (cyc == t_init);
      e_wren = e_init || (cyc == t_acc + 1);
      if (e_init) e_wdata = SENT;
      else if (cyc == t_acc + 1) e_wdata = acc_key;
      e_upd = (cyc == t_acc + 2) || (cyc == t_acc + 3);
      e_ir = m_run && (cyc >= ready_at) && !m_ov;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_in_ready", in_ready, e_ir);
    chk("cmp_out_valid", out_valid, m_ov);
    chk("cmp_wren_root", wren_root, e_wren);
    chk("cmp_initialize", initialize, e_init);
    chk("cmp_update_out", update_out, e_upd);
    chk("cmp_address", address_updated_out, 0);
    if (e_wren) chk("cmp_data_root", data_root, e_wdata);
    if (m_ov) begin
      chk("cmp_out_data", out_data, m_od);
      chk("cmp_out_empty", out_empty, m_oe);
    end
  end

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk(nm, (n < 100), 1);
  endtask

  task automatic do_init();
    int n;
    start = 1; @(posedge clk); #1; start = 0;
    chk("init_pulse", initialize, 1);
    chk("init_wren", wren_root, 1);
    chk("init_data", data_root, 16'hFFFF);
    chk("init_ready_low", in_ready, 0);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("init_to_ready", n, 1 + SPACING);
  endtask

  task automatic do_replace(input logic [WIDTH:0] key, input logic [WIDTH:0] exp_pop,
                            input logic exp_empty, input logic consume);
    int n;
    out_ready = consume; in_data = key; in_valid = 1;
    wait_ready("accept_wait", n);
    @(posedge clk); #1; in_valid = 0;
    chk("read_wren", wren_root, 0);
    @(posedge clk); #1;
    chk("write_wren", wren_root, 1);
    chk("write_data", data_root, key);
    @(posedge clk); #1;
    chk("pop_valid", out_valid, 1);
    chk("pop_data", out_data, exp_pop);
    chk("pop_empty", out_empty, exp_empty);
    chk("upd_first", update_out, 1);
    chk("upd_addr", address_updated_out, 0);
    @(posedge clk); #1;
    chk("upd_second", update_out, 1);
    chk("pop_hold", out_valid, !consume);
    chk("gap_wren", wren_root, 0);
    @(posedge clk); #1;
    chk("upd_end", update_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0] keys [4];
    int last, k, n;
    keys[0] = 16'h0100; keys[1] = 16'h0200; keys[2] = 16'h0300; keys[3] = 16'h0400;
    rst = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_wren", wren_root, 0);
    chk("rst_init", initialize, 0);
    chk("rst_update", update_out, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_data_root", data_root, 0);
    rst = 1;
    @(posedge clk); #1;
    in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_ready", in_ready, 0);
    in_valid = 0;

    do_init();
    do_replace(16'h0005, 16'hFFFF, 1, 1);
    do_replace(16'h0010, 16'h0005, 0, 1);
    do_replace(16'hFFFF, 16'h0010, 0, 1);
    do_replace(16'hFFFF, 16'hFFFF, 1, 1);

    // Backpressure: popped key must sit still while the consumer stalls.
    do_replace(16'h0020, 16'hFFFF, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 16'hFFFF);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    start = 1; @(posedge clk); #1; start = 0;
    chk("start_ignored_init", initialize, 0);
    chk("start_ignored_wren", wren_root, 0);

    // Streaming: continuous requests are taken exactly 5+SPACING cycles apart.
    last = -1; k = 0;
    in_valid = 1; in_data = keys[0];
    for (int c = 0; c < 60 && k < 4; c++) begin
      if (in_ready) begin
        if (last >= 0) chk("accept_gap", c - last, 9);
        last = c; k++;
        @(posedge clk); #1;
        if (k < 4) in_data = keys[k];
        else in_valid = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
    chk("stream_count", k, 4);
    do_replace(16'h0030, 16'h0400, 0, 1);

    // Asynchronous reset during the update pulse.
    in_data = 16'h0555; in_valid = 1;
    wait_ready("rst_accept_wait", n);
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_update", update_out, 1);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst = 0;
    #1;
    chk("async_update", update_out, 0);
    chk("async_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    @(posedge clk); #1; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", in_ready, 0);

    do_init();
    do_replace(16'h0007, 16'hFFFF, 1, 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
